// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: IDLE/BUSY/DONE handshake with pipeline stall.
// Optional access counters are enabled by defining DMEM_ACCESS_COUNT_EN.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        misaligned
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] readCount,
    output logic [31:0] writeCount
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         read_data_q, read_data_d;
    logic                mem_we;
    logic                load_done;
    logic                req;

    logic [31:0] mem [DEPTH] = '{default: '0};

    // Upper address bits only select aliases of the same word.
    logic unused_addr;
    assign unused_addr = ^{address[31:ADDR_W+2]};

    assign req = memRead | memWrite;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        stall       = 1'b0;
        misaligned  = 1'b0;
        mem_we      = 1'b0;
        load_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (address[1:0] == 2'b00) begin
                        stall   = 1'b1;
                        op_wr_d = memWrite;
                        idx_d   = address[ADDR_W+1:2];
                        wdata_d = writeData;
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = BUSY;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        load_done   = 1'b1;
                        read_data_d = mem[idx_q];
                    end
                end
            end
            // The completed request is still presented this cycle, so inputs are ignored.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Reset wins over a store completing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign readData = read_data_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] read_count_q, read_count_d;
    logic [31:0] write_count_q, write_count_d;

    always_comb begin
        read_count_d  = read_count_q + {31'd0, load_done};
        write_count_d = write_count_q + {31'd0, mem_we};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_count_q  <= 32'd0;
            write_count_q <= 32'd0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign readCount  = read_count_q;
    assign writeCount = write_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, ADDR_W=8); counter checks when DMEM_ACCESS_COUNT_EN is defined.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        misaligned;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] readCount;
    logic [31:0] writeCount;
`endif

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .stall      (stall),
        .misaligned (misaligned)
`ifdef DMEM_ACCESS_COUNT_EN
        ,
        .readCount  (readCount),
        .writeCount (writeCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at a falling edge; returns at the falling edge of the IDLE cycle after DONE.
    // exp_rd is the readData required in DONE (the old value for stores).
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        memRead = rd; memWrite = wr; address = a; writeData = d;
        #1;
        chk("stall_req", {31'd0, stall}, 32'd1);
        chk("mis_req", {31'd0, misaligned}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("stall_busy", {31'd0, stall}, 32'd1);
            chk("mis_busy", {31'd0, misaligned}, 32'd0);
            // Latched copies must be used, not the live inputs.
            address   = a ^ 32'h4;
            writeData = ~d;
        end
        @(negedge clk); #1;
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("rdata_done", readData, exp_rd);
        memRead = 1'b0; memWrite = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = 32'd0; writeData = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_rdata", readData, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0);
        access(1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);

        memRead = 1'b1; address = 32'h13;
        #1;
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        memRead = 1'b0; address = 32'd0;
        #1;
        chk("mis_idle_stall", {31'd0, stall}, 32'd0);
        chk("mis_clear", {31'd0, misaligned}, 32'd0);
        chk("mis_rdata", readData, 32'hDEADBEEF);
        @(negedge clk);

        access(1'b0, 1'b1, 32'h400, 32'h12345678, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h0, 32'd0, 32'h12345678);

        access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h12345678);
        access(1'b1, 1'b0, 32'h20, 32'd0, 32'hA5A5A5A5);

        memWrite = 1'b1; address = 32'h40; writeData = 32'h1;
        #1;
        chk("abort_stall_req", {31'd0, stall}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; memWrite = 1'b0;
        @(negedge clk); #1;
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_rdata", readData, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        access(1'b1, 1'b0, 32'h40, 32'd0, 32'd0);

`ifdef DMEM_ACCESS_COUNT_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("cnt_rd_init", readCount, 32'd0);
        chk("cnt_wr_init", writeCount, 32'd0);
        @(negedge clk);
        access(1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h0, 32'd0, 32'h12345678);
        access(1'b1, 1'b0, 32'h20, 32'd0, 32'hA5A5A5A5);
        access(1'b0, 1'b1, 32'h44, 32'h7, 32'hA5A5A5A5);
        access(1'b0, 1'b1, 32'h48, 32'h9, 32'hA5A5A5A5);
        memRead = 1'b1; address = 32'h11;
        @(negedge clk);
        memRead = 1'b0; address = 32'd0;
        #1;
        chk("cnt_rd", readCount, 32'd3);
        chk("cnt_wr", writeCount, 32'd2);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("cnt_rd_rst", readCount, 32'd0);
        chk("cnt_wr_rst", writeCount, 32'd0);
        reset = 1'b0;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline.
- Consumes the MEM-side request from the EX/MEM pipeline register: address from ALU result, store data, memRead, memWrite.
- Performs the word access after a configurable latency and holds the pipeline via stall until the access completes.
- Returns load data for the MEM/WB register.

Parameters:
- ADDR_W, 8, word-index width; memory depth = 2**ADDR_W words of 32 bits.
- LATENCY, 2, BUSY cycles per access; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- memRead  input  1  load request; held stable by the pipeline while stall=1.
- memWrite  input  1  store request; held stable while stall=1.
- address  input  32  byte address (ALU result).
- writeData  input  32  store data (register read data 2).
- readData  output  32  load result; valid in the DONE cycle, then held.
- stall  output  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- misaligned  output  1  one-cycle flag: request with address[1:0]!=0 was rejected.
- readCount  output  32  completed loads (only with the optional feature).
- writeCount  output  32  completed stores (only with the optional feature).

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: state=IDLE, readData=0, stall=0, misaligned=0, counters=0. Memory array is not cleared by reset; it is zero-initialised at time 0.
- Word index = address[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Request = memRead | memWrite. If both are asserted, the request is a store and the read is ignored.

FSM states: IDLE, BUSY, DONE.
- IDLE, request present and address[1:0]==0:
  - stall=1 combinationally in the same cycle.
  - Latch op, index and writeData; cnt<=LATENCY-1; go to BUSY.
- IDLE, request present and address[1:0]!=0:
  - misaligned=1 combinationally this cycle.
  - stall=0, no access, remain in IDLE.
- IDLE, no request: stall=0, remain in IDLE.
- BUSY:
  - stall=1.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: perform the access and go to DONE. A store writes mem[index]<=latched data; a load sets readData<=mem[index].
- DONE:
  - stall=0 and inputs are ignored, because the same request is still at the EX/MEM outputs this cycle.
  - Go to IDLE unconditionally.
- Timing: a request first seen in cycle T gives stall=1 for cycles T..T+LATENCY and DONE in cycle T+LATENCY+1.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE.
- readData changes only on load completion or reset. Stores leave it unchanged.
- Inputs changing while stall=1 are ignored; the latched copy is used.
- Reset mid-operation (BUSY): abort with no memory write; go to IDLE, stall=0, readData=0.
- Reset has priority over all other events in the same cycle.
- misaligned is combinational from the inputs while in IDLE and is 0 in the BUSY and DONE states.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- Defined:
  - readCount and writeCount ports exist.
  - Each increments by 1 at completion, on the BUSY-to-DONE edge, of a load or store respectively.
  - Both wrap at 2**32 and are cleared by reset.
  - Misaligned and aborted requests are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan (LATENCY=2, ADDR_W=8):
- Store then load: store writeData=0xDEADBEEF to address=0x10, then load 0x10. Each request gives stall high 3 cycles then low 1 cycle; readData=0xDEADBEEF in the load's DONE cycle.
- Misaligned: memRead=1, address=0x13. Required: misaligned=1 for that cycle, stall=0, readData unchanged, state stays IDLE.
- Wrap-around: store 0x12345678 to address=0x400, then load address=0x0. Required: readData=0x12345678.
- Both asserted: memRead=memWrite=1, address=0x20, writeData=0xA5A5A5A5. Required: treated as a store; readData unchanged; a later load of 0x20 returns 0xA5A5A5A5.
- Reset mid-store: store 0x1 to 0x40, assert reset in the 2nd BUSY cycle. Required: next cycle stall=0, readData=0; a later load of 0x40 returns its prior value 0x0.
- With DMEM_ACCESS_COUNT_EN: 3 loads, 2 stores and 1 misaligned load. Required: readCount=3, writeCount=2; after reset both are 0.
